pipeline_hazard_ctrl: RTL and testbench

//  Pipeline sequencing controller for the 5-stage CPU. It sits beside the forwarding unit.
//  It resolves the hazards that forwarding cannot cover:
//   - load-use: stall plus bubble
//   - taken branch: flush
//   - multi-cycle MUL/DIV: hold EX for N cycles, then pulse the R0/Rd write
//   - HALT: freeze the pipeline
//  It also counts stall cycles for performance measurement.

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 13 +
 rtl/pipeline_hazard_ctrl_if.sv | 46 ++++
 rtl/pipeline_hazard_ctrl_load_use_detect.sv | 19 +
 rtl/pipeline_hazard_ctrl.sv | 117 +++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and widths for the pipeline hazard controller.
// The state encoding is fixed so debug views and checkers can decode it.
package pipeline_hazard_ctrl_pkg;

  localparam int REGISTER_NUMBER_BIT_WIDTH = 4;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_MULDIV = 2'd1,
    ST_HALT   = 2'd2
  } hz_state_e;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Bundle of pipeline-side hazard inputs and controller outputs.
// The master is the pipeline/driver side, the slave is the hazard controller.
interface pipeline_hazard_ctrl_if
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int RNW       = REGISTER_NUMBER_BIT_WIDTH,
  parameter int CNT_WIDTH = 16
) ();

  logic [RNW-1:0]       RN1_ID;
  logic [RNW-1:0]       RN2_ID;
  logic                 UsesRN2_ID;
  logic [RNW-1:0]       RN1_EX;
  logic                 WriteReg_EX;
  logic                 MemRead_EX;
  logic                 BranchTaken_EX;
  logic                 IsMulDiv_EX;
  logic                 Halt_EX;

  logic                 Stall_PC;
  logic                 Stall_IFID;
  logic                 Stall_IDEX;
  logic                 Bubble_IDEX;
  logic                 Flush_IFID;
  logic                 Bubble_EXMEM;
  logic                 MulDiv_busy;
  logic                 MulDiv_done;
  logic                 Halted;
  logic [CNT_WIDTH-1:0] Stall_count;
  hz_state_e            dbg_state;

  modport master (
    output RN1_ID, RN2_ID, UsesRN2_ID, RN1_EX, WriteReg_EX, MemRead_EX,
           BranchTaken_EX, IsMulDiv_EX, Halt_EX,
    input  Stall_PC, Stall_IFID, Stall_IDEX, Bubble_IDEX, Flush_IFID,
           Bubble_EXMEM, MulDiv_busy, MulDiv_done, Halted, Stall_count, dbg_state
  );

  modport slave (
    input  RN1_ID, RN2_ID, UsesRN2_ID, RN1_EX, WriteReg_EX, MemRead_EX,
           BranchTaken_EX, IsMulDiv_EX, Halt_EX,
    output Stall_PC, Stall_IFID, Stall_IDEX, Bubble_IDEX, Flush_IFID,
           Bubble_EXMEM, MulDiv_busy, MulDiv_done, Halted, Stall_count, dbg_state
  );

endinterface

// File: rtl/pipeline_hazard_ctrl_load_use_detect.sv
// Load-use hazard compare: a load in EX whose destination feeds an ID source.
module load_use_detect
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int RNW = REGISTER_NUMBER_BIT_WIDTH
) (
  input  logic [RNW-1:0] rn1_id_i,
  input  logic [RNW-1:0] rn2_id_i,
  input  logic           uses_rn2_id_i,
  input  logic [RNW-1:0] rn1_ex_i,
  input  logic           write_reg_ex_i,
  input  logic           mem_read_ex_i,
  output logic           hazard_o
);

  assign hazard_o = mem_read_ex_i & write_reg_ex_i &
                    ((rn1_id_i == rn1_ex_i) | (uses_rn2_id_i & (rn2_id_i == rn1_ex_i)));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencing controller: load-use stall, branch flush, multi-cycle
// MUL/DIV hold, HALT freeze, and a saturating stall-cycle counter.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int REGISTER_NUMBER_BIT_WIDTH = pipeline_hazard_ctrl_pkg::REGISTER_NUMBER_BIT_WIDTH,
  parameter int MULDIV_CYCLES             = 16,
  parameter int CNT_WIDTH                 = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  pipeline_hazard_ctrl_if.slave bus
);

  // Counter only has to hold MULDIV_CYCLES-2; the entry cycle is spent in RUN.
  localparam int CW = (MULDIV_CYCLES > 2) ? $clog2(MULDIV_CYCLES - 1) : 1;
  localparam logic [CW-1:0] MD_LOAD = CW'(MULDIV_CYCLES - 2);

  hz_state_e            state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] stall_count_q;

  logic load_use;
  logic stall_pc, stall_ifid, stall_idex, bubble_idex, flush_ifid;
  logic bubble_exmem, muldiv_busy, muldiv_done, halted;

  load_use_detect #(.RNW(REGISTER_NUMBER_BIT_WIDTH)) u_load_use (
    .rn1_id_i       (bus.RN1_ID),
    .rn2_id_i       (bus.RN2_ID),
    .uses_rn2_id_i  (bus.UsesRN2_ID),
    .rn1_ex_i       (bus.RN1_EX),
    .write_reg_ex_i (bus.WriteReg_EX),
    .mem_read_ex_i  (bus.MemRead_EX),
    .hazard_o       (load_use)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    stall_pc     = 1'b0;
    stall_ifid   = 1'b0;
    stall_idex   = 1'b0;
    bubble_idex  = 1'b0;
    flush_ifid   = 1'b0;
    bubble_exmem = 1'b0;
    muldiv_busy  = 1'b0;
    muldiv_done  = 1'b0;
    halted       = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        if (bus.Halt_EX) begin
          {stall_pc, stall_ifid, stall_idex, bubble_exmem} = 4'b1111;
          state_d = ST_HALT;
        end else if (bus.BranchTaken_EX) begin
          // Flush beats a simultaneous load-use: the stalled instruction is discarded.
          flush_ifid  = 1'b1;
          bubble_idex = 1'b1;
        end else if (bus.IsMulDiv_EX) begin
          {stall_pc, stall_ifid, stall_idex, bubble_exmem} = 4'b1111;
          muldiv_busy = 1'b1;
          cnt_d       = MD_LOAD;
          state_d     = ST_MULDIV;
        end else if (load_use) begin
          stall_pc    = 1'b1;
          stall_ifid  = 1'b1;
          bubble_idex = 1'b1;
        end
      end
      ST_MULDIV: begin
        if (cnt_q != '0) begin
          {stall_pc, stall_ifid, stall_idex, bubble_exmem} = 4'b1111;
          muldiv_busy = 1'b1;
          cnt_d       = cnt_q - 1'b1;
        end else begin
          muldiv_done = 1'b1;
          state_d     = ST_RUN;
        end
      end
      ST_HALT: begin
        {stall_pc, stall_ifid, stall_idex, bubble_exmem} = 4'b1111;
        halted = 1'b1;
      end
      default: state_d = ST_RUN;
    endcase
    // Inputs can still be active during reset; keep every control output quiet.
    if (!rst_n) begin
      {stall_pc, stall_ifid, stall_idex, bubble_idex, flush_ifid} = 5'b0;
      {bubble_exmem, muldiv_busy, muldiv_done, halted}            = 4'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_RUN;
      cnt_q         <= '0;
      stall_count_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (stall_pc && !halted && (stall_count_q != '1))
        stall_count_q <= stall_count_q + 1'b1;
    end
  end

  assign bus.Stall_PC     = stall_pc;
  assign bus.Stall_IFID   = stall_ifid;
  assign bus.Stall_IDEX   = stall_idex;
  assign bus.Bubble_IDEX  = bubble_idex;
  assign bus.Flush_IFID   = flush_ifid;
  assign bus.Bubble_EXMEM = bubble_exmem;
  assign bus.MulDiv_busy  = muldiv_busy;
  assign bus.MulDiv_done  = muldiv_done;
  assign bus.Halted       = halted;
  assign bus.Stall_count  = stall_count_q;
  assign bus.dbg_state    = state_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: a 16-bit counter instance and a
// 4-bit counter instance share the same stimulus.
module tb_pipeline_hazard_ctrl;
  import pipeline_hazard_ctrl_pkg::*;

  localparam int RNW = 4;
  localparam int MDC = 16;

  // Output vector: {Stall_PC, Stall_IFID, Stall_IDEX, Bubble_IDEX, Flush_IFID,
  //                 Bubble_EXMEM, MulDiv_busy, MulDiv_done, Halted}
  localparam logic [8:0] E_NONE = 9'b0_0_0_0_0_0_0_0_0;
  localparam logic [8:0] E_LU   = 9'b1_1_0_1_0_0_0_0_0;
  localparam logic [8:0] E_BR   = 9'b0_0_0_1_1_0_0_0_0;
  localparam logic [8:0] E_MD   = 9'b1_1_1_0_0_1_1_0_0;
  localparam logic [8:0] E_DONE = 9'b0_0_0_0_0_0_0_1_0;
  localparam logic [8:0] E_HENT = 9'b1_1_1_0_0_1_0_0_0;
  localparam logic [8:0] E_HLT  = 9'b1_1_1_0_0_1_0_0_1;

  typedef struct packed {
    logic [RNW-1:0] rn1_id;
    logic [RNW-1:0] rn2_id;
    logic           uses2;
    logic [RNW-1:0] rn1_ex;
    logic           wr;
    logic           mr;
    logic           br;
    logic           md;
    logic           hl;
  } in_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pipeline_hazard_ctrl_if #(.RNW(RNW), .CNT_WIDTH(16)) bus  ();
  pipeline_hazard_ctrl_if #(.RNW(RNW), .CNT_WIDTH(4))  bus4 ();

  assign bus4.RN1_ID         = bus.RN1_ID;
  assign bus4.RN2_ID         = bus.RN2_ID;
  assign bus4.UsesRN2_ID     = bus.UsesRN2_ID;
  assign bus4.RN1_EX         = bus.RN1_EX;
  assign bus4.WriteReg_EX    = bus.WriteReg_EX;
  assign bus4.MemRead_EX     = bus.MemRead_EX;
  assign bus4.BranchTaken_EX = bus.BranchTaken_EX;
  assign bus4.IsMulDiv_EX    = bus.IsMulDiv_EX;
  assign bus4.Halt_EX        = bus.Halt_EX;

  pipeline_hazard_ctrl #(.REGISTER_NUMBER_BIT_WIDTH(RNW), .MULDIV_CYCLES(MDC), .CNT_WIDTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  pipeline_hazard_ctrl #(.REGISTER_NUMBER_BIT_WIDTH(RNW), .MULDIV_CYCLES(MDC), .CNT_WIDTH(4)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4)
  );

  logic [8:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int exp_cnt  = 0;

  function automatic in_t mk(input int a, input int b, input logic u, input int d,
                             input logic wr, input logic mr, input logic br,
                             input logic md, input logic hl);
    in_t s;
    s.rn1_id = RNW'(a);
    s.rn2_id = RNW'(b);
    s.uses2  = u;
    s.rn1_ex = RNW'(d);
    s.wr = wr; s.mr = mr; s.br = br; s.md = md; s.hl = hl;
    return s;
  endfunction

  function automatic logic [8:0] outs();
    return {bus.Stall_PC, bus.Stall_IFID, bus.Stall_IDEX, bus.Bubble_IDEX, bus.Flush_IFID,
            bus.Bubble_EXMEM, bus.MulDiv_busy, bus.MulDiv_done, bus.Halted};
  endfunction

  function automatic int sat4(input int c);
    return (c > 15) ? 15 : c;
  endfunction

  task automatic set_in(input in_t s);
    bus.RN1_ID         = s.rn1_id;
    bus.RN2_ID         = s.rn2_id;
    bus.UsesRN2_ID     = s.uses2;
    bus.RN1_EX         = s.rn1_ex;
    bus.WriteReg_EX    = s.wr;
    bus.MemRead_EX     = s.mr;
    bus.BranchTaken_EX = s.br;
    bus.IsMulDiv_EX    = s.md;
    bus.Halt_EX        = s.hl;
  endtask

  task automatic drive(input in_t s, input logic [8:0] e);
    @(posedge clk);
    #1;
    set_in(s);
    exp_q.push_back(e);
  endtask

  task automatic test_reset();
    logic [8:0] e;
    rst_n = 1'b0;
    set_in(mk(3, 3, 1'b1, 3, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0));
    exp_q.push_back(E_NONE);
    exp_cnt = 0;
    repeat (2) @(negedge clk);
    e = exp_q.pop_front();
    n_checks++;
    if (outs() !== e) begin n_fail++; $display("FAIL reset_outs: got %b expected %b", outs(), e); end
    n_checks++;
    if (bus.Stall_count !== 16'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", bus.Stall_count); end
    n_checks++;
    if (bus4.Stall_count !== 4'd0) begin n_fail++; $display("FAIL reset_count4: got %0d expected 0", bus4.Stall_count); end
    n_checks++;
    if (bus.dbg_state !== ST_RUN) begin n_fail++; $display("FAIL reset_state: got %0d expected %0d", bus.dbg_state, ST_RUN); end
    set_in(mk(0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    rst_n = 1'b1;
  endtask

  task automatic test_load_use();
    in_t        stim[7];
    logic [8:0] ev[7];
    logic [8:0] e;
    stim[0] = mk(3, 0, 1'b0, 3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0); ev[0] = E_LU;
    stim[1] = mk(0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); ev[1] = E_NONE;
    stim[2] = mk(5, 3, 1'b1, 3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0); ev[2] = E_LU;
    stim[3] = mk(0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); ev[3] = E_NONE;
    stim[4] = mk(5, 3, 1'b0, 3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0); ev[4] = E_NONE;
    stim[5] = mk(3, 3, 1'b1, 3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); ev[5] = E_NONE;
    stim[6] = mk(3, 3, 1'b1, 3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0); ev[6] = E_NONE;
    for (int k = 0; k < 7 + 16; k++) begin
      if (k < 7) begin
        drive(stim[k], ev[k]);
      end else begin
        int a, b, d;
        logic u, wr, mr, hz;
        a = $urandom_range(0, 3); b = $urandom_range(0, 3); d = $urandom_range(0, 3);
        u = 1'($urandom_range(0, 1)); wr = 1'($urandom_range(0, 1)); mr = 1'($urandom_range(0, 1));
        hz = mr && wr && ((a == d) || (u && (b == d)));
        drive(mk(a, b, u, d, wr, mr, 1'b0, 1'b0, 1'b0), hz ? E_LU : E_NONE);
      end
      @(negedge clk);
      e = exp_q.pop_front();
      n_checks++;
      if (outs() !== e) begin n_fail++; $display("FAIL load_use_outs step %0d: got %b expected %b", k, outs(), e); end
      n_checks++;
      if (bus.Stall_count !== 16'(exp_cnt)) begin n_fail++; $display("FAIL load_use_count step %0d: got %0d expected %0d", k, bus.Stall_count, exp_cnt); end
      if (e[8] && !e[0]) exp_cnt++;
    end
  endtask

  task automatic test_branch();
    in_t        stim[3];
    logic [8:0] ev[3];
    logic [8:0] e;
    stim[0] = mk(3, 3, 1'b1, 3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0); ev[0] = E_BR;
    stim[1] = mk(1, 2, 1'b1, 7, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0); ev[1] = E_BR;
    stim[2] = mk(0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); ev[2] = E_NONE;
    for (int k = 0; k < 3; k++) begin
      drive(stim[k], ev[k]);
      @(negedge clk);
      e = exp_q.pop_front();
      n_checks++;
      if (outs() !== e) begin n_fail++; $display("FAIL branch_outs step %0d: got %b expected %b", k, outs(), e); end
      n_checks++;
      if (bus.Stall_count !== 16'(exp_cnt)) begin n_fail++; $display("FAIL branch_count step %0d: got %0d expected %0d", k, bus.Stall_count, exp_cnt); end
      if (e[8] && !e[0]) exp_cnt++;
    end
  endtask

  // Two MUL/DIVs back to back, then an idle cycle.
  task automatic test_back_to_back_muldiv();
    logic [8:0] e;
    int kk;
    for (int k = 1; k <= 2 * MDC + 1; k++) begin
      if (k <= 2 * MDC) begin
        kk = ((k - 1) % MDC) + 1;
        drive(mk($urandom_range(0, 3), $urandom_range(0, 3), 1'b1, $urandom_range(0, 3),
                 1'b1, 1'b1, 1'b0, 1'b1, 1'b0), (kk < MDC) ? E_MD : E_DONE);
      end else begin
        drive(mk(0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), E_NONE);
      end
      @(negedge clk);
      e = exp_q.pop_front();
      n_checks++;
      if (outs() !== e) begin n_fail++; $display("FAIL muldiv_outs cycle %0d: got %b expected %b", k, outs(), e); end
      n_checks++;
      if (bus.Stall_count !== 16'(exp_cnt)) begin n_fail++; $display("FAIL muldiv_count cycle %0d: got %0d expected %0d", k, bus.Stall_count, exp_cnt); end
      if (k == 2) begin
        n_checks++;
        if (bus.dbg_state !== ST_MULDIV) begin n_fail++; $display("FAIL muldiv_state: got %0d expected %0d", bus.dbg_state, ST_MULDIV); end
      end
      if (k == 2 * MDC + 1) begin
        n_checks++;
        if (bus.dbg_state !== ST_RUN) begin n_fail++; $display("FAIL muldiv_end_state: got %0d expected %0d", bus.dbg_state, ST_RUN); end
      end
      if (e[8] && !e[0]) exp_cnt++;
    end
  endtask

  task automatic test_muldiv_abort();
    logic [8:0] e;
    // Cycle 9 of the MUL/DIV runs with the iteration counter at 7.
    for (int k = 1; k <= 9; k++) begin
      drive(mk(0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0), E_MD);
      @(negedge clk);
      e = exp_q.pop_front();
      n_checks++;
      if (outs() !== e) begin n_fail++; $display("FAIL abort_outs cycle %0d: got %b expected %b", k, outs(), e); end
      if (e[8] && !e[0]) exp_cnt++;
    end
    #2 rst_n = 1'b0;
    exp_cnt = 0;
    #1;
    n_checks++;
    if (outs() !== E_NONE) begin n_fail++; $display("FAIL abort_reset_outs: got %b expected %b", outs(), E_NONE); end
    n_checks++;
    if (bus.dbg_state !== ST_RUN) begin n_fail++; $display("FAIL abort_reset_state: got %0d expected %0d", bus.dbg_state, ST_RUN); end
    n_checks++;
    if (bus.Stall_count !== 16'd0) begin n_fail++; $display("FAIL abort_reset_count: got %0d expected 0", bus.Stall_count); end
    @(negedge clk);
    set_in(mk(0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      drive(mk(0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), E_NONE);
      @(negedge clk);
      e = exp_q.pop_front();
      n_checks++;
      if (outs() !== e) begin n_fail++; $display("FAIL abort_after step %0d: got %b expected %b", k, outs(), e); end
    end
  endtask

  task automatic test_saturation();
    logic [8:0] e;
    for (int k = 0; k < 40; k++) begin
      if (k % 2 == 0) drive(mk(3, 0, 1'b0, 3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0), E_LU);
      else            drive(mk(0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), E_NONE);
      @(negedge clk);
      e = exp_q.pop_front();
      n_checks++;
      if (outs() !== e) begin n_fail++; $display("FAIL sat_outs step %0d: got %b expected %b", k, outs(), e); end
      n_checks++;
      if (bus.Stall_count !== 16'(exp_cnt)) begin n_fail++; $display("FAIL sat_count16 step %0d: got %0d expected %0d", k, bus.Stall_count, exp_cnt); end
      n_checks++;
      if (bus4.Stall_count !== 4'(sat4(exp_cnt))) begin n_fail++; $display("FAIL sat_count4 step %0d: got %0d expected %0d", k, bus4.Stall_count, sat4(exp_cnt)); end
      if (e[8] && !e[0]) exp_cnt++;
    end
    @(negedge clk);
    n_checks++;
    if (bus4.Stall_count !== 4'd15) begin n_fail++; $display("FAIL sat_final4: got %0d expected 15", bus4.Stall_count); end
  endtask

  task automatic test_halt();
    logic [8:0] e;
    int sel;
    for (int k = 0; k <= 50; k++) begin
      if (k == 0) begin
        drive(mk(0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1), E_HENT);
      end else begin
        sel = $urandom_range(0, 3);
        drive(mk($urandom_range(0, 3), $urandom_range(0, 3), 1'b1, $urandom_range(0, 3), 1'b1, 1'b1,
                 sel == 1, sel == 2, sel == 3), E_HLT);
      end
      @(negedge clk);
      e = exp_q.pop_front();
      n_checks++;
      if (outs() !== e) begin n_fail++; $display("FAIL halt_outs cycle %0d: got %b expected %b", k, outs(), e); end
      n_checks++;
      if (bus.Stall_count !== 16'(exp_cnt)) begin n_fail++; $display("FAIL halt_count cycle %0d: got %0d expected %0d", k, bus.Stall_count, exp_cnt); end
      if (e[8] && !e[0]) exp_cnt++;
    end
    #2 rst_n = 1'b0;
    exp_cnt = 0;
    #1;
    n_checks++;
    if (outs() !== E_NONE) begin n_fail++; $display("FAIL halt_reset_outs: got %b expected %b", outs(), E_NONE); end
    n_checks++;
    if (bus.dbg_state !== ST_RUN) begin n_fail++; $display("FAIL halt_reset_state: got %0d expected %0d", bus.dbg_state, ST_RUN); end
    n_checks++;
    if (bus.Stall_count !== 16'd0) begin n_fail++; $display("FAIL halt_reset_count: got %0d expected 0", bus.Stall_count); end
    @(negedge clk);
    set_in(mk(0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    rst_n = 1'b1;
    drive(mk(3, 0, 1'b0, 3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0), E_LU);
    @(negedge clk);
    e = exp_q.pop_front();
    n_checks++;
    if (outs() !== e) begin n_fail++; $display("FAIL halt_after_outs: got %b expected %b", outs(), e); end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_branch();
    test_back_to_back_muldiv();
    test_muldiv_abort();
    test_saturation();
    test_halt();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
